// File: rtl/text_cmd_unit_pkg.sv
// text_cmd_unit_pkg
// Shared definitions for the text display command front end:
//   - host register addresses (REG_CMD .. REG_STATUS)
//   - command codes accepted in the CMD register
//   - bit positions inside the STATUS register
//   - command FSM state encoding
package text_cmd_unit_pkg;

    localparam logic [3:0] REG_CMD    = 4'd0;
    localparam logic [3:0] REG_ARG0   = 4'd1;  // character code
    localparam logic [3:0] REG_ARG1   = 4'd2;  // attribute byte
    localparam logic [3:0] REG_ARG2   = 4'd3;  // row
    localparam logic [3:0] REG_ARG3   = 4'd4;  // column, writing it launches the command
    localparam logic [3:0] REG_STATUS = 4'd5;  // read-only

    localparam logic [7:0] CMD_WRITE_CHAR = 8'd0;
    localparam logic [7:0] CMD_FILL       = 8'd1;
    localparam logic [7:0] CMD_FILL_ROW   = 8'd2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_ERR  = 1;
    localparam int STAT_OVR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE
    } state_t;

endpackage

// File: rtl/text_cmd_unit.sv
// text_cmd_unit
// Host-side command front end of the text display card. Holds the host
// register file, launches one command at a time when ARG3 is written, and
// turns the command into a stream of cell writes on the text RAM write port.
//
// Ports:
//   cpu_clock  sole clock, rising edge
//   reset      asynchronous, active-low
//   ce, rw     host bus strobe; rw=1 write, rw=0 read
//   addr       host register select
//   data_in    host write data
//   data_out   host read data, combinational from addr
//   mem_req    cell write request (held until mem_gnt)
//   mem_gnt    text RAM accepted the presented cell this cycle
//   mem_addr   cell index row*COLS+col
//   mem_wdata  {attr, char}
//   busy       command in progress (STATUS bit 0)
module text_cmd_unit
    import text_cmd_unit_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int MEM_AW = 12
) (
    input  logic              cpu_clock,
    input  logic              reset,
    input  logic              ce,
    input  logic              rw,
    input  logic [3:0]        addr,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy
);

    localparam int                CNT_W  = MEM_AW + 1;
    localparam int                TOTAL  = COLS * ROWS;
    localparam logic [MEM_AW-1:0] COLS_A = MEM_AW'(COLS);

    // Host register file
    logic [7:0] reg_cmd, reg_arg0, reg_arg1, reg_arg2, reg_arg3;
    logic       stat_err, stat_ovr;

    // Working copy of the command being executed
    logic [7:0] w_cmd, w_char, w_attr, w_row, w_col;

    logic [MEM_AW-1:0] idx_q;
    logic [CNT_W-1:0]  cnt_q;
    state_t            state_q, state_d;

    logic host_wr, host_rd, go_wr, go_wr_q, trigger;

    logic              setup_err;
    logic [MEM_AW-1:0] setup_start;
    logic [CNT_W-1:0]  setup_cnt;
    logic [MEM_AW-1:0] row_base;
    logic              row_ok, col_ok;
    logic              last_cell;

    assign host_wr = ce && rw;
    assign host_rd = ce && !rw;
    assign go_wr   = host_wr && (addr == REG_ARG3);
    // Only the first cycle of a sustained ARG3 write launches a command.
    assign trigger = go_wr && !go_wr_q;

    assign busy      = (state_q != ST_IDLE);
    assign mem_req   = (state_q == ST_WRITE);
    assign mem_addr  = idx_q;
    assign mem_wdata = {w_attr, w_char};
    assign last_cell = (cnt_q == CNT_W'(1));

    // Range check and start index / cell count, used during SETUP
    always_comb begin
        row_ok      = ({24'd0, w_row} < ROWS);
        col_ok      = ({24'd0, w_col} < COLS);
        row_base    = MEM_AW'(w_row) * COLS_A;
        setup_err   = 1'b0;
        setup_start = '0;
        setup_cnt   = '0;
        case (w_cmd)
            CMD_WRITE_CHAR: begin
                setup_err   = !(row_ok && col_ok);
                setup_start = row_base + MEM_AW'(w_col);
                setup_cnt   = CNT_W'(1);
            end
            CMD_FILL: begin
                setup_start = '0;
                setup_cnt   = CNT_W'(TOTAL);
            end
            CMD_FILL_ROW: begin
                setup_err   = !row_ok;
                setup_start = row_base;
                setup_cnt   = CNT_W'(COLS);
            end
            default: setup_err = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (trigger) state_d = ST_SETUP;
            ST_SETUP: state_d = setup_err ? ST_IDLE : ST_WRITE;
            ST_WRITE: if (mem_gnt && last_cell) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            reg_cmd  <= '0;
            reg_arg0 <= '0;
            reg_arg1 <= '0;
            reg_arg2 <= '0;
            reg_arg3 <= '0;
            stat_err <= 1'b0;
            stat_ovr <= 1'b0;
            go_wr_q  <= 1'b0;
            w_cmd    <= '0;
            w_char   <= '0;
            w_attr   <= '0;
            w_row    <= '0;
            w_col    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            go_wr_q <= go_wr;

            if (host_wr) begin
                case (addr)
                    REG_CMD:  reg_cmd  <= data_in;
                    REG_ARG0: reg_arg0 <= data_in;
                    REG_ARG1: reg_arg1 <= data_in;
                    REG_ARG2: reg_arg2 <= data_in;
                    REG_ARG3: reg_arg3 <= data_in;
                    default: ;
                endcase
            end

            // Column comes from the bus directly since ARG3 updates on this same edge.
            if (trigger) begin
                if (state_q == ST_IDLE) begin
                    w_cmd    <= reg_cmd;
                    w_char   <= reg_arg0;
                    w_attr   <= reg_arg1;
                    w_row    <= reg_arg2;
                    w_col    <= data_in;
                    stat_err <= 1'b0;
                end else begin
                    stat_ovr <= 1'b1;
                end
            end

            if (host_rd && (addr == REG_STATUS)) begin
                stat_err <= 1'b0;
                stat_ovr <= 1'b0;
            end

            // A fresh error outranks a status read on the same edge.
            case (state_q)
                ST_SETUP: begin
                    if (setup_err) begin
                        stat_err <= 1'b1;
                    end else begin
                        idx_q <= setup_start;
                        cnt_q <= setup_cnt;
                    end
                end
                ST_WRITE: begin
                    if (mem_gnt && !last_cell) begin
                        idx_q <= idx_q + MEM_AW'(1);
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Host read mux
    always_comb begin
        data_out = 8'd0;
        case (addr)
            REG_CMD:    data_out = reg_cmd;
            REG_ARG0:   data_out = reg_arg0;
            REG_ARG1:   data_out = reg_arg1;
            REG_ARG2:   data_out = reg_arg2;
            REG_ARG3:   data_out = reg_arg3;
            REG_STATUS: begin
                data_out[STAT_BUSY] = busy;
                data_out[STAT_ERR]  = stat_err;
                data_out[STAT_OVR]  = stat_ovr;
            end
            default: data_out = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_text_cmd_unit.sv
// tb_text_cmd_unit
// Directed bench for text_cmd_unit: host register writes/reads, the
// cell write stream on the RAM port, error/overrun status, and reset abort.
module tb_text_cmd_unit;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int MEM_AW = 12;

    logic              cpu_clock = 1'b0;
    logic              reset     = 1'b0;
    logic              ce        = 1'b0;
    logic              rw        = 1'b0;
    logic [3:0]        addr      = 4'd0;
    logic [7:0]        data_in   = 8'd0;
    logic [7:0]        data_out;
    logic              mem_req;
    logic              mem_gnt   = 1'b0;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;

    text_cmd_unit #(.COLS(COLS), .ROWS(ROWS), .MEM_AW(MEM_AW)) dut (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .ce        (ce),
        .rw        (rw),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy)
    );

    always #5 cpu_clock = ~cpu_clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Grant driver: 0 = never, 1 = always, 2 = random 50%
    int gnt_mode = 1;
    initial begin
        forever begin
            @(posedge cpu_clock);
            #1;
            case (gnt_mode)
                0:       mem_gnt = 1'b0;
                1:       mem_gnt = 1'b1;
                default: mem_gnt = $urandom_range(0, 1) == 1;
            endcase
        end
    end

    // RAM port monitor: logs accepted writes and checks request stability
    logic [MEM_AW-1:0] log_addr [0:4095];
    logic [15:0]       log_data [0:4095];
    int                wr_total  = 0;
    int                req_cnt   = 0;
    int                hold_errs = 0;
    logic              pend      = 1'b0;
    logic [MEM_AW-1:0] pend_addr = '0;
    logic [15:0]       pend_data = '0;

    always @(negedge cpu_clock) begin
        if (reset) begin
            if (pend && !(mem_req && mem_addr == pend_addr && mem_wdata == pend_data))
                hold_errs = hold_errs + 1;
            if (mem_req) req_cnt = req_cnt + 1;
            if (mem_req && mem_gnt && wr_total < 4096) begin
                log_addr[wr_total] = mem_addr;
                log_data[wr_total] = mem_wdata;
                wr_total = wr_total + 1;
            end
            pend      = mem_req && !mem_gnt;
            pend_addr = mem_addr;
            pend_data = mem_wdata;
        end else begin
            pend = 1'b0;
        end
    end

    task automatic step();
        @(negedge cpu_clock);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        step();
        ce = 1'b1; rw = 1'b1; addr = a; data_in = d;
        step();
        ce = 1'b0; rw = 1'b0; addr = 4'd0;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] d);
        step();
        ce = 1'b1; rw = 1'b0; addr = a;
        #1 d = data_out;
        step();
        ce = 1'b0; addr = 4'd0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic launch(input logic [7:0] c, input logic [7:0] ch, input logic [7:0] at,
                          input logic [7:0] row, input logic [7:0] col);
        host_write(4'd0, c);
        host_write(4'd1, ch);
        host_write(4'd2, at);
        host_write(4'd3, row);
        host_write(4'd4, col);
    endtask

    // Count of ascending-order breaks in the log between [from, to)
    function automatic int order_breaks(input int from, input int to);
        int e = 0;
        for (int i = from + 1; i < to; i++)
            if (log_addr[i] != log_addr[i-1] + MEM_AW'(1)) e++;
        return e;
    endfunction

    logic [7:0] rd;
    int         base, rbase, nb, n;

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        reset = 1'b1;
        step();
        host_read(4'd5, rd);
        chk("rst_status", 32'(rd), 32'h00);

        // WRITE_CHAR at (1,1), grant tied high
        gnt_mode = 1;
        base = wr_total;
        launch(8'd0, 8'hB0, 8'h07, 8'd1, 8'd1);
        nb = 0;
        while (busy && nb < 50) begin
            nb++;
            step();
        end
        chk("wc_busy_cycles", 32'(nb), 32'd2);
        chk("wc_writes", 32'(wr_total - base), 32'd1);
        chk("wc_addr", 32'(log_addr[base]), 32'd81);
        chk("wc_wdata", 32'(log_data[base]), 32'h07B0);
        host_read(4'd4, rd);
        chk("arg3_readback", 32'(rd), 32'd1);

        // WRITE_CHAR at the last cell (29,79)
        base = wr_total;
        launch(8'd0, 8'h41, 8'h1F, 8'd29, 8'd79);
        wait_idle("wc_last_idle", 50);
        chk("wc_last_writes", 32'(wr_total - base), 32'd1);
        chk("wc_last_addr", 32'(log_addr[base]), 32'd2399);
        chk("wc_last_wdata", 32'(log_data[base]), 32'h1F41);

        // FILL_ROW 29 with random grants
        gnt_mode = 2;
        base = wr_total;
        launch(8'd2, 8'h20, 8'h0E, 8'd29, 8'd0);
        wait_idle("fr_idle", 2000);
        chk("fr_writes", 32'(wr_total - base), 32'd80);
        chk("fr_first", 32'(log_addr[base]), 32'd2320);
        chk("fr_last", 32'(log_addr[base + 79]), 32'd2399);
        chk("fr_order", 32'(order_breaks(base, wr_total)), 32'd0);
        chk("fr_hold", 32'(hold_errs), 32'd0);
        chk("fr_wdata", 32'(log_data[base + 40]), 32'h0E20);

        // Row out of range: error, no request
        gnt_mode = 1;
        base  = wr_total;
        rbase = req_cnt;
        launch(8'd0, 8'h41, 8'h07, 8'd30, 8'd0);
        chk("err_busy_setup", 32'(busy), 32'd1);
        step();
        chk("err_busy_drop", 32'(busy), 32'd0);
        chk("err_no_req", 32'(req_cnt - rbase), 32'd0);
        host_read(4'd5, rd);
        chk("err_status", 32'(rd), 32'h02);
        host_read(4'd5, rd);
        chk("err_status_clr", 32'(rd), 32'h00);

        // Column out of range, then invalid command code
        launch(8'd0, 8'h41, 8'h07, 8'd0, 8'd80);
        wait_idle("col_idle", 10);
        host_read(4'd5, rd);
        chk("col_err_status", 32'(rd), 32'h02);
        launch(8'd7, 8'h41, 8'h07, 8'd0, 8'd0);
        wait_idle("inv_idle", 10);
        host_read(4'd5, rd);
        chk("inv_err_status", 32'(rd), 32'h02);
        chk("err_no_writes", 32'(wr_total - base), 32'd0);

        // FILL with ARG3 held for 5 cycles, then an overrunning trigger
        base = wr_total;
        host_write(4'd0, 8'd1);
        host_write(4'd1, 8'h2E);
        host_write(4'd2, 8'h70);
        step();
        ce = 1'b1; rw = 1'b1; addr = 4'd4; data_in = 8'd0;
        repeat (5) step();
        ce = 1'b0; rw = 1'b0; addr = 4'd0;
        host_read(4'd5, rd);
        chk("hold_one_trigger", 32'(rd), 32'h01);
        repeat (20) step();
        host_write(4'd4, 8'd3);
        host_read(4'd5, rd);
        chk("ovr_status_busy", 32'(rd), 32'h05);
        host_write(4'd4, 8'd5);
        wait_idle("fill_idle", 3000);
        chk("fill_writes", 32'(wr_total - base), 32'd2400);
        chk("fill_first", 32'(log_addr[base]), 32'd0);
        chk("fill_last", 32'(log_addr[base + 2399]), 32'd2399);
        chk("fill_order", 32'(order_breaks(base, wr_total)), 32'd0);
        chk("fill_wdata", 32'(log_data[base + 1234]), 32'h702E);
        host_read(4'd5, rd);
        chk("ovr_status", 32'(rd), 32'h04);
        host_read(4'd5, rd);
        chk("ovr_status_clr", 32'(rd), 32'h00);

        // Reset in the middle of a FILL after 100 writes
        base = wr_total;
        host_write(4'd4, 8'd0);
        n = 0;
        while ((wr_total - base) < 100 && n < 500) begin
            step();
            n++;
        end
        chk("abort_reached_100", 32'(wr_total - base), 32'd100);
        @(posedge cpu_clock);
        #2 reset = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rbase = req_cnt;
        repeat (3) step();
        reset = 1'b1;
        repeat (20) step();
        chk("abort_no_writes", 32'(wr_total - base), 32'd100);
        chk("abort_no_req", 32'(req_cnt - rbase), 32'd0);
        host_read(4'd0, rd);
        chk("abort_cmd_cleared", 32'(rd), 32'd0);
        host_read(4'd5, rd);
        chk("abort_status", 32'(rd), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation limit reached, checks=%0d", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
